sdram_aref: RTL and testbench

Periodic auto-refresh engine for the SDRAM controller. It sits directly downstream of the power-up initialisation block and is enabled by that block's init_end flag. It counts the refresh interval and accumulates owed refreshes. It requests the command bus from the arbiter and, once granted, issues precharge-all followed by AR_NUM auto-refresh commands with tRP/tRFC spacing, then signals completion.

---
 rtl/sdram_aref.sv | 135 +++++++++++++
 tb/tb_sdram_aref.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_aref.sv
// SDRAM periodic auto-refresh engine: tracks owed refreshes, requests the command bus,
// and once granted issues PRECHARGE-all followed by AR_NUM AUTO REFRESH commands.
module sdram_aref #(
    parameter int unsigned CNT_REF_MAX = 750,
    parameter int unsigned TRP         = 2,
    parameter int unsigned TRFC        = 7,
    parameter int unsigned AR_NUM      = 2,
    parameter int unsigned PEND_MAX    = 8
) (
    input  logic        aref_clk,
    input  logic        aref_rst,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_bank,
    output logic [12:0] aref_addr,
    output logic        aref_end,
    output logic [3:0]  aref_pend,
    output logic        aref_ovf
);

    localparam int unsigned CW   = (CNT_REF_MAX > 1) ? $clog2(CNT_REF_MAX) : 1;
    localparam int unsigned WMAX = (TRP > TRFC) ? TRP : TRFC;
    localparam int unsigned WW   = $clog2(WMAX + 1);

    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_TRP  = 3'd2;
    localparam logic [2:0] S_AR   = 3'd3;
    localparam logic [2:0] S_TRFC = 3'd4;
    localparam logic [2:0] S_END  = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_wait;
    logic [3:0]    r_ar_cnt;
    logic [3:0]    r_pend;
    logic [3:0]    w_pend_nxt;
    logic          r_ovf;
    logic          w_ovf_nxt;
    logic          r_req;
    logic          r_end;
    logic [3:0]    r_cmd;
    logic          w_tick;

    assign w_tick = init_end && (r_cnt == CW'(CNT_REF_MAX - 1));

    // Owed-refresh bookkeeping; a tick and a completion in the same cycle cancel out.
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf;
        if (!init_end) begin
            w_pend_nxt = '0;
        end else if (w_tick && !r_end) begin
            if (r_pend == 4'(PEND_MAX)) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_pend_nxt = r_pend + 4'd1;
            end
        end else if (!w_tick && r_end && (r_pend != 4'd0)) begin
            w_pend_nxt = r_pend - 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_req && aref_en) w_state_nxt = S_PRE;
            S_PRE:  w_state_nxt = S_TRP;
            S_TRP:  if (r_wait == WW'(TRP - 1)) w_state_nxt = S_AR;
            S_AR:   w_state_nxt = S_TRFC;
            S_TRFC: begin
                if (r_wait == WW'(TRFC - 1)) begin
                    w_state_nxt = (r_ar_cnt < 4'(AR_NUM)) ? S_AR : S_END;
                end
            end
            S_END:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aref_clk) begin
        if (aref_rst) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Outputs are registered from the next state so commands line up with the state they name.
    always_ff @(posedge aref_clk) begin
        if (aref_rst) begin
            r_cnt    <= '0;
            r_wait   <= '0;
            r_ar_cnt <= '0;
            r_pend   <= '0;
            r_ovf    <= 1'b0;
            r_req    <= 1'b0;
            r_end    <= 1'b0;
            r_cmd    <= CMD_NOP;
        end else begin
            if (!init_end || w_tick) r_cnt <= '0;
            else                     r_cnt <= r_cnt + CW'(1);

            if (w_state_nxt != r_state)                   r_wait <= '0;
            else if (r_state == S_TRP || r_state == S_TRFC) r_wait <= r_wait + WW'(1);

            if (r_state == S_IDLE)    r_ar_cnt <= '0;
            else if (r_state == S_AR) r_ar_cnt <= r_ar_cnt + 4'd1;

            r_pend <= w_pend_nxt;
            r_ovf  <= w_ovf_nxt;
            r_req  <= init_end && (w_state_nxt == S_IDLE) && (w_pend_nxt != 4'd0);
            r_end  <= (w_state_nxt == S_END);

            case (w_state_nxt)
                S_PRE:   r_cmd <= CMD_PRE;
                S_AR:    r_cmd <= CMD_AR;
                default: r_cmd <= CMD_NOP;
            endcase
        end
    end

    assign aref_req  = r_req;
    assign aref_cmd  = r_cmd;
    assign aref_bank = 2'b11;
    assign aref_addr = 13'h1fff;
    assign aref_end  = r_end;
    assign aref_pend = r_pend;
    assign aref_ovf  = r_ovf;

endmodule

// File: tb/tb_sdram_aref.sv
// Scoreboard bench for sdram_aref: grants push expected command events, a negedge monitor pops them.
module tb_sdram_aref;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] AR  = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic       fin;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        init_end;
    logic        aref_en;
    logic        aref_req;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_bank;
    logic [12:0] aref_addr;
    logic        aref_end;
    logic [3:0]  aref_pend;
    logic        aref_ovf;

    int  cyc;
    int  n_chk;
    int  n_pass;
    int  n_fail;
    int  t0;
    ev_t exp_q[$];

    sdram_aref #(.CNT_REF_MAX(20)) dut (
        .aref_clk (clk),
        .aref_rst (rst),
        .init_end (init_end),
        .aref_en  (aref_en),
        .aref_req (aref_req),
        .aref_cmd (aref_cmd),
        .aref_bank(aref_bank),
        .aref_addr(aref_addr),
        .aref_end (aref_end),
        .aref_pend(aref_pend),
        .aref_ovf (aref_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [3:0] cmd, input logic fin);
        ev_t e;
        e.cyc = c;
        e.cmd = cmd;
        e.fin = fin;
        exp_q.push_back(e);
    endtask

    // Grant at cycle g; full=0 pushes only the events that precede a planned mid-sequence reset.
    task automatic grant(input int g, input bit full);
        wait_to(g);
        chk("req_at_grant", 32'(aref_req), 32'd1);
        push(g + 1, PRE, 1'b0);
        push(g + 4, AR, 1'b0);
        if (full) begin
            push(g + 12, AR, 1'b0);
            push(g + 20, NOP, 1'b1);
        end
        aref_en = 1'b1;
        @(negedge clk);
        aref_en = 1'b0;
    endtask

    task automatic chk_rp(input int c, input logic req, input logic [3:0] pend);
        wait_to(c);
        chk("req", 32'(aref_req), 32'(req));
        chk("pend", 32'(aref_pend), 32'(pend));
    endtask

    // Monitor: every non-NOP command or end pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (cyc > 0 && (aref_cmd !== NOP || aref_end !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                chk("spurious_event", {27'd0, aref_end, aref_cmd}, {27'd0, 1'b0, NOP});
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_cycle", 32'(cyc), 32'(e.cyc));
                chk("ev_cmd", 32'(aref_cmd), 32'(e.cmd));
                chk("ev_end", 32'(aref_end), 32'(e.fin));
                chk("ev_bank_addr", {17'd0, aref_bank, aref_addr}, {17'd0, 2'b11, 13'h1fff});
            end
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1; init_end = 1'b0; aref_en = 1'b0;

        // Reset then long idle with init_end low.
        wait_to(3);
        rst = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            wait_to(c);
            if (c % 10 == 1) begin
                chk("idle_cmd", 32'(aref_cmd), 32'(NOP));
                chk("idle_req", 32'(aref_req), 32'd0);
                chk("idle_pend", 32'(aref_pend), 32'd0);
            end
        end
        chk("idle_ovf", 32'(aref_ovf), 32'd0);

        // Single refresh: first tick at t0+19.
        wait_to(2001);
        t0 = cyc;
        init_end = 1'b1;
        chk_rp(t0 + 19, 1'b0, 4'd0);
        chk_rp(t0 + 20, 1'b1, 4'd1);
        grant(t0 + 20, 1'b1);
        chk_rp(t0 + 21, 1'b0, 4'd1);
        chk_rp(t0 + 40, 1'b0, 4'd2);
        chk_rp(t0 + 41, 1'b1, 4'd1);

        // Tick coincides with aref_end at t0+79.
        grant(t0 + 59, 1'b1);
        chk_rp(t0 + 79, 1'b0, 4'd2);
        chk_rp(t0 + 80, 1'b1, 4'd2);

        // Backlog then two back-to-back sequences.
        chk_rp(t0 + 150, 1'b1, 4'd5);
        grant(t0 + 150, 1'b1);
        chk_rp(t0 + 170, 1'b0, 4'd6);
        chk_rp(t0 + 171, 1'b1, 4'd5);
        grant(t0 + 171, 1'b1);
        chk_rp(t0 + 191, 1'b0, 4'd6);
        chk_rp(t0 + 192, 1'b1, 4'd5);

        // Saturation and overflow.
        chk_rp(t0 + 259, 1'b1, 4'd8);
        chk("ovf_pre", 32'(aref_ovf), 32'd0);
        chk_rp(t0 + 260, 1'b1, 4'd8);
        chk("ovf_set", 32'(aref_ovf), 32'd1);
        grant(t0 + 279, 1'b1);
        chk_rp(t0 + 299, 1'b0, 4'd8);
        chk_rp(t0 + 300, 1'b1, 4'd8);

        // Mid-sequence reset at g+6.
        grant(t0 + 300, 1'b0);
        wait_to(t0 + 306);
        rst = 1'b1;
        wait_to(t0 + 307);
        rst = 1'b0;
        chk("rst_cmd", 32'(aref_cmd), 32'(NOP));
        chk("rst_end", 32'(aref_end), 32'd0);
        chk("rst_ovf", 32'(aref_ovf), 32'd0);
        chk_rp(t0 + 307, 1'b0, 4'd0);
        chk_rp(t0 + 326, 1'b0, 4'd0);
        chk_rp(t0 + 327, 1'b1, 4'd1);

        // init_end drop at g+5: sequence completes, nothing more owed.
        grant(t0 + 327, 1'b1);
        wait_to(t0 + 332);
        init_end = 1'b0;
        chk_rp(t0 + 333, 1'b0, 4'd0);
        chk_rp(t0 + 348, 1'b0, 4'd0);
        chk_rp(t0 + 420, 1'b0, 4'd0);
        chk("final_ovf", 32'(aref_ovf), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
